// File: rtl/rv_fork_source_pkg.sv
// Shared types and helpers for the rv_fork_source ready/valid fork transmitter.
package rv_fork_pkg;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_LANES = 3;
    localparam int PTR_W     = $clog2(DEF_DEPTH);
    localparam int LANE_W    = $clog2(DEF_LANES);

    typedef struct packed {
        logic                 res;
        logic [DEF_WIDTH-1:0] data;
    } entry_t;

    // Operands arrive zero-extended; bits at or above w are ignored.
    function automatic logic reduce_res(input logic [31:0] in1, input logic [31:0] in2,
                                        input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (|(in1 & mask)) & (&(in2 | ~mask));
    endfunction

endpackage

// File: rtl/rv_fork_source_if.sv
// Upstream sample port plus the handshake / handshake_arr downstream channels.
interface rv_fork_source_if #(
    parameter int WIDTH = 5,
    parameter int LANES = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             handshake_valid;
    logic             handshake_ready;
    logic             out;
    logic [LANES-1:0] handshake_arr_valid;
    logic [LANES-1:0] handshake_arr_ready;
    logic [WIDTH-1:0] lane_data;

    modport master (
        input  in_valid, in1, in2, handshake_ready, handshake_arr_ready,
        output in_ready, handshake_valid, out, handshake_arr_valid, lane_data
    );

    modport slave (
        output in_valid, in1, in2, handshake_ready, handshake_arr_ready,
        input  in_ready, handshake_valid, out, handshake_arr_valid, lane_data
    );
endinterface

// File: rtl/rv_fork_source_fifo.sv
// Small synchronous FIFO with a combinational head view; async active-high reset.
module rv_fork_fifo #(
    parameter int DW    = 6,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rv_fork_source.sv
// Ready/valid fork source: each buffered entry is sent as a 1-bit result and as lane data
// on a round-robin lane. Optional checks enabled by RV_FORK_SOURCE_ASSERT_EN.
module rv_fork_source
    import rv_fork_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LANES = DEF_LANES
) (
    input logic               CLK,
    input logic               ASYNCRESET,
    rv_fork_source_if.master  bus
);
    localparam int LB = (LANES > 1) ? $clog2(LANES) : 1;

    typedef struct packed {
        logic             res;
        logic [WIDTH-1:0] data;
    } head_t;

    head_t         wentry, head;
    logic          full, empty, push, pop;
    logic          rdy_q;
    logic          p_done_q, p_done_d;
    logic          l_done_q, l_done_d;
    logic [LB-1:0] rr_ptr_q, rr_ptr_d;
    logic          p_hs, l_hs, lane_active;

    assign wentry.res  = reduce_res(32'(bus.in1), 32'(bus.in2), WIDTH);
    assign wentry.data = bus.in1 ^ bus.in2;

    // rdy_q keeps in_ready low throughout reset without using the reset net as data.
    assign bus.in_ready = rdy_q && !full;
    assign push         = bus.in_valid && bus.in_ready;

    rv_fork_fifo #(
        .DW    ($bits(head_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (ASYNCRESET),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign bus.handshake_valid = !empty && !p_done_q;
    assign bus.out             = empty ? 1'b0 : head.res;
    assign bus.lane_data       = empty ? '0 : head.data;
    assign lane_active         = !empty && !l_done_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign bus.handshake_arr_valid[gi] = lane_active && (rr_ptr_q == LB'(gi));
    end

    // Only the selected lane can be valid, so readies on other lanes drop out here.
    assign p_hs = bus.handshake_valid && bus.handshake_ready;
    assign l_hs = |(bus.handshake_arr_valid & bus.handshake_arr_ready);
    assign pop  = !empty && (p_done_q || p_hs) && (l_done_q || l_hs);

    always_comb begin
        p_done_d = p_done_q || p_hs;
        l_done_d = l_done_q || l_hs;
        rr_ptr_d = rr_ptr_q;
        if (pop) begin
            p_done_d = 1'b0;
            l_done_d = 1'b0;
            rr_ptr_d = (rr_ptr_q == LB'(LANES - 1)) ? '0 : rr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            rdy_q    <= 1'b0;
            p_done_q <= 1'b0;
            l_done_q <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            rdy_q    <= 1'b1;
            p_done_q <= p_done_d;
            l_done_q <= l_done_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef RV_FORK_SOURCE_ASSERT_EN
    a_hs_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET)
        bus.handshake_valid && !bus.handshake_ready |=> bus.handshake_valid && $stable(bus.out));

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_chk
        a_lane_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET)
            bus.handshake_arr_valid[gi] && !bus.handshake_arr_ready[gi]
            |=> bus.handshake_arr_valid[gi] && $stable(bus.lane_data));
    end

    a_onehot: assert property (@(posedge CLK) disable iff (ASYNCRESET)
        $onehot0(bus.handshake_arr_valid));

    a_no_push_full: assert property (@(posedge CLK) disable iff (ASYNCRESET)
        !(push && full));
`endif

endmodule

// File: tb/tb_rv_fork_source.sv
// Directed self-checking bench for rv_fork_source (WIDTH=5, DEPTH=2, LANES=3).
module tb_rv_fork_source;

    logic CLK;
    logic ASYNCRESET;
    int   n_tests = 0;
    int   n_fail  = 0;

    rv_fork_source_if #(.WIDTH(5), .LANES(3)) ifc ();

    rv_fork_source #(.WIDTH(5), .DEPTH(2), .LANES(3)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .bus        (ifc.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic ir, input logic hv, input logic o,
                              input logic [2:0] av, input logic [4:0] ld);
        $display("[TB] %s: in_ready=%b hs_valid=%b out=%b arr_valid=%b lane_data=%h",
                 tag, ifc.in_ready, ifc.handshake_valid, ifc.out,
                 ifc.handshake_arr_valid, ifc.lane_data);
        chk({tag, ".in_ready"},  32'(ifc.in_ready), 32'(ir));
        chk({tag, ".hs_valid"},  32'(ifc.handshake_valid), 32'(hv));
        chk({tag, ".out"},       32'(ifc.out), 32'(o));
        chk({tag, ".arr_valid"}, 32'(ifc.handshake_arr_valid), 32'(av));
        chk({tag, ".lane_data"}, 32'(ifc.lane_data), 32'(ld));
    endtask

    task automatic drv(input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic hr, input logic [2:0] ar);
        ifc.in_valid            = v;
        ifc.in1                 = a;
        ifc.in2                 = b;
        ifc.handshake_ready     = hr;
        ifc.handshake_arr_ready = ar;
    endtask

    logic [4:0] rr_a   [4] = '{5'h01, 5'h00, 5'h1F, 5'h0A};
    logic [4:0] rr_b   [4] = '{5'h1F, 5'h1F, 5'h0F, 5'h1F};
    logic       rr_res [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [4:0] rr_dat [4] = '{5'h1E, 5'h1F, 5'h10, 5'h15};
    logic [2:0] rr_lane[4] = '{3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ASYNCRESET = 1'b1;
        drv(0, 5'h00, 5'h00, 0, 3'b000);
        #2;
        expect_out("reset", 0, 0, 0, 3'b000, 5'h00);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        @(negedge CLK);
        expect_out("post_reset", 1, 0, 0, 3'b000, 5'h00);

        // single entry, both channels ready: visible next cycle, pops on the following edge
        drv(1, 5'h1F, 5'h1F, 1, 3'b111);
        @(negedge CLK);
        expect_out("t1_head", 1, 1, 1, 3'b001, 5'h00);
        drv(0, 5'h00, 5'h00, 1, 3'b111);
        @(negedge CLK);
        expect_out("t1_pop", 1, 0, 0, 3'b000, 5'h00);

        // fork skew on lane 1: result channel completes first, lane held
        drv(1, 5'h03, 5'h1F, 1, 3'b000);
        @(negedge CLK);
        expect_out("t2_head", 1, 1, 1, 3'b010, 5'h1C);
        drv(0, 5'h00, 5'h00, 1, 3'b000);
        @(negedge CLK);
        expect_out("t2_skew1", 1, 0, 1, 3'b010, 5'h1C);
        @(negedge CLK);
        expect_out("t2_skew2", 1, 0, 1, 3'b010, 5'h1C);
        drv(0, 5'h00, 5'h00, 1, 3'b010);
        @(negedge CLK);
        expect_out("t2_pop", 1, 0, 0, 3'b000, 5'h00);

        // back-to-back entries starting on lane 2, wrapping through 0,1,2
        for (int i = 0; i < 4; i++) begin
            drv(1, rr_a[i], rr_b[i], 1, 3'b111);
            @(negedge CLK);
            expect_out($sformatf("t3_entry%0d", i), 1, 1, rr_res[i], rr_lane[i], rr_dat[i]);
        end
        drv(0, 5'h00, 5'h00, 1, 3'b111);
        @(negedge CLK);
        expect_out("t3_empty", 1, 0, 0, 3'b000, 5'h00);

        // backpressure until full, then drain in order while the third push waits
        drv(1, 5'h11, 5'h1F, 0, 3'b000);
        @(negedge CLK);
        expect_out("t4_a", 1, 1, 1, 3'b001, 5'h0E);
        drv(1, 5'h04, 5'h00, 0, 3'b000);
        @(negedge CLK);
        expect_out("t4_full", 0, 1, 1, 3'b001, 5'h0E);
        drv(1, 5'h1F, 5'h1F, 0, 3'b000);
        @(negedge CLK);
        expect_out("t4_held", 0, 1, 1, 3'b001, 5'h0E);
        drv(1, 5'h1F, 5'h1F, 1, 3'b001);
        @(negedge CLK);
        expect_out("t4_b", 1, 1, 0, 3'b010, 5'h04);
        drv(1, 5'h1F, 5'h1F, 1, 3'b010);
        @(negedge CLK);
        expect_out("t4_c", 1, 1, 1, 3'b100, 5'h00);
        drv(0, 5'h00, 5'h00, 1, 3'b100);
        @(negedge CLK);
        expect_out("t4_empty", 1, 0, 0, 3'b000, 5'h00);

        // advance to lane 1, then show that lane 0 ready is ignored
        drv(1, 5'h02, 5'h1F, 1, 3'b111);
        @(negedge CLK);
        expect_out("t5_d", 1, 1, 1, 3'b001, 5'h1D);
        drv(0, 5'h00, 5'h00, 1, 3'b001);
        @(negedge CLK);
        expect_out("t5_d_pop", 1, 0, 0, 3'b000, 5'h00);
        drv(1, 5'h1F, 5'h1E, 0, 3'b001);
        @(negedge CLK);
        expect_out("t5_e", 1, 1, 0, 3'b010, 5'h01);
        drv(0, 5'h00, 5'h00, 0, 3'b001);
        @(negedge CLK);
        expect_out("t5_nosel", 1, 1, 0, 3'b010, 5'h01);
        drv(0, 5'h00, 5'h00, 1, 3'b001);
        @(negedge CLK);
        expect_out("t5_ponly", 1, 0, 0, 3'b010, 5'h01);
        drv(0, 5'h00, 5'h00, 0, 3'b010);
        @(negedge CLK);
        expect_out("t5_pop", 1, 0, 0, 3'b000, 5'h00);

        // reset mid-cycle with two entries queued and the result channel done
        drv(1, 5'h01, 5'h01, 0, 3'b000);
        @(negedge CLK);
        expect_out("t6_f", 1, 1, 0, 3'b100, 5'h00);
        drv(1, 5'h07, 5'h1F, 1, 3'b000);
        @(negedge CLK);
        expect_out("t6_pdone", 0, 0, 0, 3'b100, 5'h00);
        drv(0, 5'h00, 5'h00, 0, 3'b000);
        #2;
        ASYNCRESET = 1'b1;
        #1;
        expect_out("t6_rst", 0, 0, 0, 3'b000, 5'h00);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        @(negedge CLK);
        expect_out("t6_release", 1, 0, 0, 3'b000, 5'h00);
        drv(1, 5'h1F, 5'h1F, 1, 3'b111);
        @(negedge CLK);
        expect_out("t6_lane0", 1, 1, 1, 3'b001, 5'h00);
        drv(0, 5'h00, 5'h00, 1, 3'b111);
        @(negedge CLK);
        expect_out("t6_end", 1, 0, 0, 3'b000, 5'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
